// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/bubble/flush controller with multi-cycle EX hold
// Optional STALL_PERF_EN macro enables the saturating stall_cycles counter.
module pipeline_hazard_ctrl #(
  parameter int STAGES   = 6,
  parameter int MC_STAGE = 3,
  parameter int CNT_W    = 6,
  parameter int FS_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_cycles,
  input  logic              flush_req,
  input  logic [FS_W-1:0]   flush_stage,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic [STAGES-1:0] flush,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [31:0]       stall_cycles
);

  localparam logic [FS_W-1:0]  LAST_F = FS_W'(STAGES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic {IDLE, PEND} pend_state_t;

  pend_state_t       state_q, state_d;
  logic [FS_W-1:0]   pend_f_q, pend_f_d;
  logic [CNT_W-1:0]  cnt;

  logic              mc_hold;
  logic [STAGES-1:0] src;
  logic [STAGES-1:0] reach;
  logic [STAGES-1:0] bubble_raw;
  logic [STAGES-1:0] flush_mask;
  logic [FS_W-1:0]   new_f;
  logic [FS_W-1:0]   eff_f;
  logic              new_valid;
  logic              active;
  logic              blocked;
  logic              fire;

  // Multi-cycle hold: the start cycle itself holds, then cnt covers the remaining N-1 cycles.
  assign mc_hold = (mc_start && (mc_cycles != '0)) || (cnt != '0);
  assign mc_busy = (cnt != '0);
  assign mc_done = !rst && ((cnt == ONE) ||
                            (mc_start && (mc_cycles == ONE) && (cnt == '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end else if (mc_start && (mc_cycles > ONE)) begin
      cnt <= mc_cycles - ONE;
    end
  end

  // reach[i] = some stall source sits at index >= i, i.e. stage i must hold.
  always_comb begin
    logic acc;
    src = stall_req;
    src[MC_STAGE] = stall_req[MC_STAGE] | mc_hold;
    acc = 1'b0;
    reach = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc = acc | src[i];
      reach[i] = acc;
    end
  end

  always_comb begin
    bubble_raw = '0;
    for (int i = 1; i < STAGES; i++) begin
      bubble_raw[i] = reach[i-1] & ~reach[i];
    end
  end

  // A fresh request replaces any pending one; F=0 requests are ignored entirely.
  always_comb begin
    new_f     = (flush_stage > LAST_F) ? LAST_F : flush_stage;
    new_valid = flush_req && (flush_stage != '0);
    eff_f     = new_valid ? new_f : pend_f_q;
    active    = new_valid || (state_q == PEND);
    blocked   = reach[eff_f];
    fire      = active && !blocked && !rst;
    flush_mask = ~({STAGES{1'b1}} << eff_f);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_f_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_f_q <= pend_f_d;
    end
  end

  always_comb begin
    state_d  = IDLE;
    pend_f_d = pend_f_q;
    if (active && blocked) begin
      state_d  = PEND;
      pend_f_d = eff_f;
    end
  end

  // Flush wins over stall/bubble for the flushed younger stages.
  always_comb begin
    stall  = '0;
    bubble = '0;
    flush  = '0;
    if (!rst) begin
      if (fire) begin
        flush  = flush_mask;
        stall  = reach & ~flush_mask;
        bubble = bubble_raw & ~flush_mask;
      end else begin
        stall  = reach;
        bubble = bubble_raw;
      end
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if ((|stall) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - table-driven and sequence checks for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_req;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic        flush_req;
  logic [2:0]  flush_stage;
  logic [5:0]  stall;
  logic [5:0]  bubble;
  logic [5:0]  flush;
  logic        mc_busy;
  logic        mc_done;
  logic [31:0] stall_cycles;

  int checks;
  int failures;

  pipeline_hazard_ctrl #(
    .STAGES(6), .MC_STAGE(3), .CNT_W(6), .FS_W(3)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .mc_start(mc_start),
    .mc_cycles(mc_cycles), .flush_req(flush_req), .flush_stage(flush_stage),
    .stall(stall), .bubble(bubble), .flush(flush), .mc_busy(mc_busy),
    .mc_done(mc_done), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [5:0] sr;
    logic       ms;
    logic [5:0] mn;
    logic       fr;
    logic [2:0] fs;
    logic [5:0] st;
    logic [5:0] bu;
    logic [5:0] fl;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [5:0] st, input logic [5:0] bu,
                         input logic [5:0] fl, input logic busy, input logic done);
    chk({name, "_stall"}, {26'd0, stall}, {26'd0, st});
    chk({name, "_bubble"}, {26'd0, bubble}, {26'd0, bu});
    chk({name, "_flush"}, {26'd0, flush}, {26'd0, fl});
    chk({name, "_busy"}, {31'd0, mc_busy}, {31'd0, busy});
    chk({name, "_done"}, {31'd0, mc_done}, {31'd0, done});
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 3 units later.
  task automatic drive(input logic r, input logic [5:0] sr, input logic ms, input logic [5:0] mn,
                       input logic fr, input logic [2:0] fs);
    @(posedge clk);
    #1;
    rst = r; stall_req = sr; mc_start = ms; mc_cycles = mn; flush_req = fr; flush_stage = fs;
    #3;
  endtask

  task automatic idle();
    drive(1'b0, 6'b0, 1'b0, 6'd0, 1'b0, 3'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; stall_req = '0; mc_start = 1'b0; mc_cycles = '0; flush_req = 1'b0; flush_stage = '0;

    // Outputs forced low while reset is held, even with every request active.
    drive(1'b1, 6'b111111, 1'b1, 6'd5, 1'b1, 3'd3);
    chk_all("reset_hold", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    drive(1'b1, 6'b0, 1'b0, 6'd0, 1'b0, 3'd0);
    chk_all("reset_idle", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);

    //             sr         ms    mn    fr    fs    stall      bubble     flush      busy  done
    tbl[0]  = '{6'b000000, 1'b0, 6'd0, 1'b0, 3'd0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b0};
    tbl[1]  = '{6'b000100, 1'b0, 6'd0, 1'b0, 3'd0, 6'b000111, 6'b001000, 6'b000000, 1'b0, 1'b0};
    tbl[2]  = '{6'b100000, 1'b0, 6'd0, 1'b0, 3'd0, 6'b111111, 6'b000000, 6'b000000, 1'b0, 1'b0};
    tbl[3]  = '{6'b000001, 1'b0, 6'd0, 1'b0, 3'd0, 6'b000001, 6'b000010, 6'b000000, 1'b0, 1'b0};
    tbl[4]  = '{6'b010010, 1'b0, 6'd0, 1'b0, 3'd0, 6'b011111, 6'b100000, 6'b000000, 1'b0, 1'b0};
    tbl[5]  = '{6'b000000, 1'b0, 6'd0, 1'b1, 3'd2, 6'b000000, 6'b000000, 6'b000011, 1'b0, 1'b0};
    tbl[6]  = '{6'b000000, 1'b0, 6'd0, 1'b1, 3'd7, 6'b000000, 6'b000000, 6'b011111, 1'b0, 1'b0};
    tbl[7]  = '{6'b000000, 1'b0, 6'd0, 1'b1, 3'd0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b0};
    tbl[8]  = '{6'b000010, 1'b0, 6'd0, 1'b1, 3'd3, 6'b000000, 6'b000000, 6'b000111, 1'b0, 1'b0};
    tbl[9]  = '{6'b000010, 1'b0, 6'd0, 1'b1, 3'd2, 6'b000000, 6'b000100, 6'b000011, 1'b0, 1'b0};
    tbl[10] = '{6'b000100, 1'b0, 6'd0, 1'b1, 3'd2, 6'b000111, 6'b001000, 6'b000000, 1'b0, 1'b0};
    tbl[11] = '{6'b000000, 1'b0, 6'd0, 1'b0, 3'd0, 6'b000000, 6'b000000, 6'b000011, 1'b0, 1'b0};
    tbl[12] = '{6'b000000, 1'b0, 6'd0, 1'b0, 3'd0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b0};
    tbl[13] = '{6'b001000, 1'b0, 6'd0, 1'b1, 3'd3, 6'b001111, 6'b010000, 6'b000000, 1'b0, 1'b0};
    tbl[14] = '{6'b000000, 1'b0, 6'd0, 1'b1, 3'd1, 6'b000000, 6'b000000, 6'b000001, 1'b0, 1'b0};
    tbl[15] = '{6'b000000, 1'b0, 6'd0, 1'b0, 3'd0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b0};
    tbl[16] = '{6'b000000, 1'b1, 6'd1, 1'b0, 3'd0, 6'b001111, 6'b010000, 6'b000000, 1'b0, 1'b1};
    tbl[17] = '{6'b000000, 1'b0, 6'd0, 1'b0, 3'd0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b0};
    tbl[18] = '{6'b000000, 1'b1, 6'd0, 1'b0, 3'd0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b0};

    for (int i = 0; i < 19; i++) begin
      drive(1'b0, tbl[i].sr, tbl[i].ms, tbl[i].mn, tbl[i].fr, tbl[i].fs);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].bu, tbl[i].fl, tbl[i].busy, tbl[i].done);
    end

    // Four-cycle multi-cycle hold.
    drive(1'b0, 6'b0, 1'b1, 6'd4, 1'b0, 3'd0);
    chk_all("mc4_t0", 6'b001111, 6'b010000, 6'b0, 1'b0, 1'b0);
    idle(); chk_all("mc4_t1", 6'b001111, 6'b010000, 6'b0, 1'b1, 1'b0);
    idle(); chk_all("mc4_t2", 6'b001111, 6'b010000, 6'b0, 1'b1, 1'b0);
    idle(); chk_all("mc4_t3", 6'b001111, 6'b010000, 6'b0, 1'b1, 1'b1);
    idle(); chk_all("mc4_t4", 6'b000000, 6'b000000, 6'b0, 1'b0, 1'b0);

    // Flush colliding with the hold is deferred until the hold ends.
    drive(1'b0, 6'b0, 1'b1, 6'd3, 1'b0, 3'd0);
    chk_all("pend_t0", 6'b001111, 6'b010000, 6'b0, 1'b0, 1'b0);
    drive(1'b0, 6'b0, 1'b0, 6'd0, 1'b1, 3'd2);
    chk_all("pend_t1", 6'b001111, 6'b010000, 6'b0, 1'b1, 1'b0);
    idle(); chk_all("pend_t2", 6'b001111, 6'b010000, 6'b0, 1'b1, 1'b1);
    idle(); chk_all("pend_t3", 6'b000000, 6'b000000, 6'b000011, 1'b0, 1'b0);
    idle(); chk_all("pend_t4", 6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b0);

    // A second mc_start while busy must not extend the hold.
    drive(1'b0, 6'b0, 1'b1, 6'd3, 1'b0, 3'd0);
    drive(1'b0, 6'b0, 1'b1, 6'd5, 1'b0, 3'd0);
    chk_all("restart_t1", 6'b001111, 6'b010000, 6'b0, 1'b1, 1'b0);
    idle(); chk_all("restart_t2", 6'b001111, 6'b010000, 6'b0, 1'b1, 1'b1);
    idle(); chk_all("restart_t3", 6'b000000, 6'b000000, 6'b0, 1'b0, 1'b0);

    // Reset in the middle of an eight-cycle hold aborts it.
    drive(1'b0, 6'b0, 1'b1, 6'd8, 1'b0, 3'd0);
    idle();
    idle(); chk_all("abort_t2", 6'b001111, 6'b010000, 6'b0, 1'b1, 1'b0);
    drive(1'b1, 6'b0, 1'b0, 6'd0, 1'b0, 3'd0);
    chk("abort_t3_stall", {26'd0, stall}, 32'd0);
    chk("abort_t3_done", {31'd0, mc_done}, 32'd0);
    for (int i = 4; i < 10; i++) begin
      idle();
      chk_all($sformatf("abort_t%0d", i), 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    end

`ifdef STALL_PERF_EN
    drive(1'b1, 6'b0, 1'b0, 6'd0, 1'b0, 3'd0);
    idle();
    chk("perf_cleared", stall_cycles, 32'd0);
    for (int i = 0; i < 10; i++) drive(1'b0, 6'b000010, 1'b0, 6'd0, 1'b0, 3'd0);
    idle();
    chk("perf_ten", stall_cycles, 32'd10);
    idle();
    chk("perf_hold", stall_cycles, 32'd10);
`else
    chk("perf_tied_zero", stall_cycles, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
